// File: rtl/pipeline_stage_skid.sv
// Multi-lane pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// in_ready is a flop, so upstream stall logic never sees downstream out_ready combinationally.
module pipeline_stage_skid #(
  parameter int                   LANES        = 2,
  parameter int                   INSTR_W      = 32,
  parameter int                   PC_W         = 32,
  parameter logic [INSTR_W-1:0]   BUBBLE_INSTR = 32'h00000013
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FlushD,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*INSTR_W-1:0] in_instr,
  input  logic [LANES*PC_W-1:0]    in_pc,
  output logic                     in_ready,
  output logic [LANES-1:0]         out_valid,
  output logic [LANES*INSTR_W-1:0] out_instr,
  output logic [LANES*PC_W-1:0]    out_pc,
  input  logic                     out_ready,
  output logic [1:0]               occupancy
);

  // Handshake: a group moves when its side's valid (any lane) and ready are both high
  // on the same rising edge; a presented group holds its data until that happens.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     in_ready_q;
  logic [LANES-1:0]         main_v, skid_v;
  logic [LANES*INSTR_W-1:0] main_i, skid_i;
  logic [LANES*PC_W-1:0]    main_p, skid_p;

  logic [LANES*INSTR_W-1:0] in_i_m;
  logic [LANES*PC_W-1:0]    in_p_m;
  logic                     in_fire, out_fire;
  logic                     ld_main_in, ld_skid_in, mv_skid, clr_main;

  assign in_fire  = (|in_valid) & in_ready_q;
  assign out_fire = (|main_v) & out_ready;

  // Invalid lanes are turned into bubbles before they are stored.
  always_comb begin
    in_i_m = '0;
    in_p_m = '0;
    for (int i = 0; i < LANES; i++) begin
      in_i_m[i*INSTR_W +: INSTR_W] = in_valid[i] ? in_instr[i*INSTR_W +: INSTR_W] : BUBBLE_INSTR;
      in_p_m[i*PC_W +: PC_W]       = in_valid[i] ? in_pc[i*PC_W +: PC_W] : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_main_in = 1'b0;
    ld_skid_in = 1'b0;
    mv_skid    = 1'b0;
    clr_main   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_d    = TWO;
          ld_skid_in = 1'b1;
        end else if (out_fire) begin
          state_d  = EMPTY;
          clr_main = 1'b1;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          mv_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || FlushD) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_v     <= '0;
      main_i     <= {LANES{BUBBLE_INSTR}};
      main_p     <= '0;
      skid_v     <= '0;
      skid_i     <= {LANES{BUBBLE_INSTR}};
      skid_p     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (ld_main_in) begin
        main_v <= in_valid;
        main_i <= in_i_m;
        main_p <= in_p_m;
      end else if (mv_skid) begin
        main_v <= skid_v;
        main_i <= skid_i;
        main_p <= skid_p;
      end else if (clr_main) begin
        main_v <= '0;
        main_i <= {LANES{BUBBLE_INSTR}};
        main_p <= '0;
      end
      if (ld_skid_in) begin
        skid_v <= in_valid;
        skid_i <= in_i_m;
        skid_p <= in_p_m;
      end else if (mv_skid) begin
        skid_v <= '0;
        skid_i <= {LANES{BUBBLE_INSTR}};
        skid_p <= '0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign out_instr = main_i;
  assign out_pc    = main_p;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: LANES = 1, 2 and 4 instances share one stimulus bus,
// each with its own expected-group queue.
module tb_pipeline_stage_skid;

  localparam int W = 260;  // {valid[3:0], instr[127:0], pc[127:0]}
  localparam logic [31:0] NOP = 32'h00000013;

  logic         CLK = 1'b0;
  logic         RESET, FlushD, out_ready;
  logic [3:0]   in_valid;
  logic [127:0] in_instr, in_pc;

  logic         rdy1, rdy2, rdy4;
  logic [1:0]   occ1, occ2, occ4;
  logic [0:0]   ov1;
  logic [1:0]   ov2;
  logic [3:0]   ov4;
  logic [31:0]  oi1, op1;
  logic [63:0]  oi2, op2;
  logic [127:0] oi4, op4;

  logic         rdy_a[3];
  logic [1:0]   occ_a[3];
  logic [3:0]   ov_a[3];
  logic [127:0] oi_a[3], op_a[3];

  logic [W-1:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipeline_stage_skid #(.LANES(1)) u1 (
    .CLK(CLK), .RESET(RESET), .FlushD(FlushD),
    .in_valid(in_valid[0:0]), .in_instr(in_instr[31:0]), .in_pc(in_pc[31:0]),
    .in_ready(rdy1), .out_valid(ov1), .out_instr(oi1), .out_pc(op1),
    .out_ready(out_ready), .occupancy(occ1));

  pipeline_stage_skid #(.LANES(2)) u2 (
    .CLK(CLK), .RESET(RESET), .FlushD(FlushD),
    .in_valid(in_valid[1:0]), .in_instr(in_instr[63:0]), .in_pc(in_pc[63:0]),
    .in_ready(rdy2), .out_valid(ov2), .out_instr(oi2), .out_pc(op2),
    .out_ready(out_ready), .occupancy(occ2));

  pipeline_stage_skid #(.LANES(4)) u4 (
    .CLK(CLK), .RESET(RESET), .FlushD(FlushD),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(rdy4), .out_valid(ov4), .out_instr(oi4), .out_pc(op4),
    .out_ready(out_ready), .occupancy(occ4));

  assign rdy_a[0] = rdy1;  assign occ_a[0] = occ1;
  assign rdy_a[1] = rdy2;  assign occ_a[1] = occ2;
  assign rdy_a[2] = rdy4;  assign occ_a[2] = occ4;
  assign ov_a[0] = {3'b0, ov1};   assign oi_a[0] = {96'b0, oi1};  assign op_a[0] = {96'b0, op1};
  assign ov_a[1] = {2'b0, ov2};   assign oi_a[1] = {64'b0, oi2};  assign op_a[1] = {64'b0, op2};
  assign ov_a[2] = ov4;           assign oi_a[2] = oi4;           assign op_a[2] = op4;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lanes_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic int qsize(int d);
    case (d)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [W-1:0] qhead(int d);
    case (d)
      0: return exp_q0[0];
      1: return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic qpush(int d, logic [W-1:0] g);
    case (d)
      0: exp_q0.push_back(g);
      1: exp_q1.push_back(g);
      default: exp_q2.push_back(g);
    endcase
  endtask

  task automatic qpop(int d);
    case (d)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic qclear(int d);
    case (d)
      0: exp_q0.delete();
      1: exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  // Group as stored by a LANES-wide stage: invalid lanes are bubbles, absent lanes are zero.
  function automatic logic [W-1:0] make_grp(int d, logic [3:0] v_in);
    logic [3:0]   v;
    logic [127:0] ins, pcs;
    v = '0; ins = '0; pcs = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < lanes_of(d)) begin
        v[i] = v_in[i];
        ins[i*32 +: 32] = v_in[i] ? in_instr[i*32 +: 32] : NOP;
        pcs[i*32 +: 32] = v_in[i] ? in_pc[i*32 +: 32] : 32'h0;
      end
    end
    return {v, ins, pcs};
  endfunction

  task automatic check_dut(int d);
    logic [W-1:0] e;
    e = (qsize(d) > 0) ? qhead(d) : make_grp(d, 4'b0000);
    check($sformatf("out_l%0d", lanes_of(d)), {ov_a[d], oi_a[d], op_a[d]}, e);
    check($sformatf("in_ready_l%0d", lanes_of(d)), W'(rdy_a[d]), W'(qsize(d) < 2));
    check($sformatf("occupancy_l%0d", lanes_of(d)), W'(occ_a[d]), W'(qsize(d)));
  endtask

  // Check all instances, advance the model by this cycle's handshakes, then clock.
  task automatic step();
    logic [W-1:0] g;
    bit inf, outf;
    for (int d = 0; d < 3; d++) check_dut(d);
    for (int d = 0; d < 3; d++) begin
      g    = make_grp(d, in_valid);
      inf  = (g[W-1 -: 4] != 4'b0) && (qsize(d) < 2);
      outf = (qsize(d) > 0) && out_ready;
      if (RESET || FlushD) qclear(d);
      else begin
        if (outf) qpop(d);
        if (inf) qpush(d, g);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [3:0] v, input logic [31:0] pc0);
    in_valid = v;
    for (int i = 0; i < 4; i++) begin
      in_pc[i*32 +: 32]    = pc0 + 32'(4 * i);
      in_instr[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, W'(ov2), W'(2'b00));
    check({tag, "_instr"}, W'(oi2), W'({NOP, NOP}));
    check({tag, "_pc"}, W'(op2), W'(64'h0));
    check({tag, "_ready"}, W'(rdy2), W'(1'b1));
    check({tag, "_occ"}, W'(occ2), W'(2'd0));
  endtask

  initial begin
    RESET = 1'b1; FlushD = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check_idle("reset");

    // Streaming at full rate.
    for (int k = 0; k < 3; k++) begin
      offer(4'b0011, 32'(8 * k));
      step();
      check("stream_pc", W'(op2), W'({32'(8 * k + 4), 32'(8 * k)}));
      check("stream_valid", W'(ov2), W'(2'b11));
    end
    in_valid = '0;
    step(); step();

    // Backpressure fills the skid; C waits until space frees.
    out_ready = 1'b0;
    offer(4'b0011, 32'h100); step();
    offer(4'b0011, 32'h108); step();
    check("bp_occ", W'(occ2), W'(2'd2));
    check("bp_ready", W'(rdy2), W'(1'b0));
    check("bp_head", W'(op2), W'({32'h104, 32'h100}));
    offer(4'b0011, 32'h110); step(); step();
    out_ready = 1'b1;
    step(); step();
    in_valid = '0;
    step(); step();

    // Partial lane valid, then an all-invalid offer is ignored.
    out_ready = 1'b0;
    offer(4'b0001, 32'h180);
    in_instr[63:32] = 32'hDEADBEEF;
    step();
    check("part_valid", W'(ov2), W'(2'b01));
    check("part_instr1", W'(oi2[63:32]), W'(NOP));
    check("part_pc1", W'(op2[63:32]), W'(32'h0));
    offer(4'b0000, 32'h190); step(); step();
    check("zero_occ", W'(occ2), W'(2'd1));
    out_ready = 1'b1;
    step(); step();

    // Flush from TWO while a new group is offered.
    out_ready = 1'b0;
    offer(4'b0011, 32'h280); step();
    offer(4'b0011, 32'h288); step();
    FlushD = 1'b1; out_ready = 1'b1;
    offer(4'b0011, 32'h300); step();
    FlushD = 1'b0; in_valid = '0;
    check_idle("flush");
    step(); step();

    // Reset while full and stalled.
    out_ready = 1'b0;
    offer(4'b0011, 32'h380); step();
    offer(4'b0011, 32'h388); step();
    RESET = 1'b1; step();
    RESET = 1'b0; in_valid = '0;
    check_idle("midreset");
    offer(4'b0011, 32'h200); step();
    check("post_reset_pc", W'(op2), W'({32'h204, 32'h200}));
    in_valid = '0; out_ready = 1'b1;
    repeat (3) step();

    // Random stress on all three widths.
    for (int n = 0; n < 10000; n++) begin
      offer(4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) in_valid = '0;
      out_ready = ($urandom_range(0, 3) != 0);
      FlushD    = ($urandom_range(0, 49) == 0);
      RESET     = ($urandom_range(0, 199) == 0);
      step();
    end
    RESET = 1'b0; FlushD = 1'b0; in_valid = '0; out_ready = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_skid.md
Name: pipeline_stage_skid

Overview:
- Parametrised, multi-lane successor to the IF/ID pipeline register, usable between any two core pipeline stages (F->D first, then D->E).
- Replaces the bare stall/flush register with a valid/ready handshake backed by a 2-entry skid buffer. Upstream in_ready is therefore a pure register output and breaks the stall-path timing loop.
- Carries LANES instruction/PC pairs per group with per-lane valid bits, for the dual-issue fetch path.
- Flush squashes everything held and presents bubbles.

Parameters:
- LANES, 2, number of instruction/PC slots per group (>=1).
- INSTR_W, 32, instruction width per lane.
- PC_W, 32, PC width per lane.
- BUBBLE_INSTR, 32'h00000013, instruction value driven on invalid/flushed lanes (RISC-V NOP).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- FlushD  in  1  squash all held groups this cycle.
- in_valid  in  LANES  per-lane valid; the group is offered when any bit is set.
- in_instr  in  LANES*INSTR_W  lane i at bits [i*INSTR_W +: INSTR_W].
- in_pc  in  LANES*PC_W  lane i at bits [i*PC_W +: PC_W].
- in_ready  out  1  stage can accept a group; registered.
- out_valid  out  LANES  per-lane valid of the head group.
- out_instr  out  LANES*INSTR_W  head-group instructions.
- out_pc  out  LANES*PC_W  head-group PCs.
- out_ready  in  1  downstream accepts the head group (equals ~StallE).
- occupancy  out  2  number of held groups (0..2); for debug and perf counters.

Behaviour:
- Storage: main register (drives the outputs) and skid register, each holding valid mask, instr and pc.
- State encodes occupancy: EMPTY (0), ONE (main full), TWO (main and skid full). Skid is never full while main is empty.
- in_fire = (|in_valid) & in_ready. out_fire = (|out_valid) & out_ready.
- in_ready = (state != TWO), registered. It never depends combinationally on out_ready.
- Transitions when FlushD = 0:
  - EMPTY: in_fire -> ONE, input loads main.
  - ONE:
    - in_fire & out_fire -> ONE, input loads main.
    - in_fire & ~out_fire -> TWO, input loads skid.
    - ~in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - TWO (in_fire impossible):
    - out_fire -> ONE, skid moves to main.
    - otherwise hold.
- Ordering is strictly FIFO. A group in skid always exits before any later input.
- Outputs follow the main register. In EMPTY, out_valid = 0.
- Any lane whose out_valid bit is 0 drives out_instr = BUBBLE_INSTR and out_pc = 0. This holds whether the lane was invalid at input, or the stage is empty, flushed or reset. Masking is applied at register load, not combinationally at the output.
- Input lanes with in_valid = 0 are stored as bubbles even when the group is accepted.
- A group with in_valid = 0 on every lane is never accepted and never consumes an entry.
- Held data is stable while out_valid != 0 and out_ready = 0. No output bit may change.
- FlushD:
  - Next state is EMPTY, and both registers load bubble/zero/invalid.
  - FlushD overrides any in_fire or out_fire in the same cycle. A group presented with in_ready = 1 in that cycle counts as accepted upstream but is discarded.
  - in_ready is 1 on the cycle after a flush.
- RESET:
  - Same effect as FlushD and takes priority over it: state EMPTY, out_valid = 0, out_instr lanes = BUBBLE_INSTR, out_pc = 0, in_ready = 1, occupancy = 0.
  - Reset asserted mid-stream discards all held groups. No group is emitted twice after reset is released.
- Latency: 1 cycle from in_fire to out_valid when EMPTY, or when ONE with out_fire. Throughput is 1 group per cycle under continuous out_ready.
- occupancy equals the state encoding, updated on the same edge.
- No combinational path from any input to any output.

Test Plan:
- Reset, then stream: RESET held 2 cycles, then groups with in_valid = 2'b11, PCs 0x0/0x4, 0x8/0xC, 0x10/0x14, out_ready = 1 -> out_valid = 2'b11 one cycle after each in_fire, PCs in order, occupancy = 1, in_ready always 1.
- Backpressure fills skid: out_ready = 0 while groups A (PC 0x100) and B (PC 0x108) are offered -> A in main, B in skid, occupancy = 2, in_ready = 0. Group C is held off. out_ready = 1 -> outputs A, B, C in consecutive cycles with no loss or duplication.
- Partial lane valid: in_valid = 2'b01, in_instr lane 1 = 0xDEADBEEF -> out_valid = 2'b01, lane 1 out_instr = 0x00000013, out_pc lane 1 = 0. in_valid = 2'b00 is never accepted and occupancy is unchanged.
- Flush with simultaneous input: state TWO, then FlushD = 1 with out_ready = 1 and a new group offered -> next cycle out_valid = 0, occupancy = 0, in_ready = 1, all lanes BUBBLE_INSTR. No flushed PC ever appears on the output.
- Reset mid-operation: RESET asserted while in TWO with out_ready = 0 -> next cycle matches the full reset state. The first post-reset group (PC 0x200) is the only one output.
- Random valid/ready/flush stress against a scoreboard model for 10k cycles, with LANES = 1 and LANES = 4 -> strict in-order delivery, held outputs stable under stall, occupancy <= 2.
